// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_pkg
// Shared types and constants for the instruction-memory boot loader.
//   boot_state_t   : loader FSM states
//   BYTES_PER_WORD : stream bytes per instruction word
//   BOOT_WORD_W    : instruction word width
//   BYTE_W         : stream byte width
//   hdr_valid()    : checks a length header against the memory depth
// -----------------------------------------------------------------------------
package imem_boot_pkg;

  typedef enum logic [2:0] {
    LEN   = 3'd0,
    BYTES = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } boot_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BOOT_WORD_W    = 32;
  localparam int BYTE_W         = 8;

  // A header is usable when it names at least one word and no more words
  // than the memory holds.
  function automatic logic hdr_valid(input logic [BYTE_W-1:0] n,
                                     input int unsigned       depth);
    logic ok;
    ok = (n != 8'd0) && ({24'd0, n} <= depth);
    return ok;
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_if
// Groups the byte-stream handshake and the instruction-memory write port.
//   byte_valid / byte_data / byte_ready : valid/ready byte stream
//   imem_we / imem_wa / imem_wd         : instruction memory write port
// master : the loader (consumes bytes, drives the write port)
// slave  : the environment (byte source and memory)
// -----------------------------------------------------------------------------
interface imem_boot_loader_if
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 6
);

  logic                   byte_valid;
  logic [BYTE_W-1:0]      byte_data;
  logic                   byte_ready;
  logic                   imem_we;
  logic [ADDR_W-1:0]      imem_wa;
  logic [BOOT_WORD_W-1:0] imem_wd;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_wa,
    output imem_wd
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_wa,
    input  imem_wd
  );

endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Shifts stream bytes into a big-endian instruction word and counts them.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : discard any partial word and restart the byte count
//   shift_en   : a byte is being accepted this cycle
//   byte_in    : the accepted byte
//   word_out   : assembled word (first byte ends up in bits 31:24)
//   word_full  : the byte accepted this cycle completes the word
// -----------------------------------------------------------------------------
module word_assembler
  import imem_boot_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic [BYTE_W-1:0]      byte_in,
  output logic [BOOT_WORD_W-1:0] word_out,
  output logic                   word_full
);

  logic [BOOT_WORD_W-1:0] word_q;
  logic [1:0]             cnt_q;

  // Shift register and byte counter; the 2-bit counter wraps to 0 after
  // each complete word, so no explicit clear is needed between words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= 32'd0;
      cnt_q  <= 2'd0;
    end else if (clr) begin
      word_q <= 32'd0;
      cnt_q  <= 2'd0;
    end else if (shift_en) begin
      word_q <= {word_q[BOOT_WORD_W-BYTE_W-1:0], byte_in};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  // Flag the 4th byte while it is being accepted so the FSM can leave for
  // WRITE on the same edge that stores it.
  always_comb begin
    word_full = 1'b0;
    if (shift_en && (cnt_q == 2'(BYTES_PER_WORD - 1))) begin
      word_full = 1'b1;
    end else begin
      word_full = 1'b0;
    end
  end

  assign word_out = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Boot-time loader for the writable instruction memory. Accepts a
// length-prefixed byte stream (count N, then N big-endian words), writes the
// words to addresses 0..N-1 and holds the CPU in reset until the image is in.
//   clk, reset : clock, asynchronous active-high reset
//   load_start : reload request, honoured only in DONE or ERR
//   bus        : master side of the byte stream + imem write port
//   cpu_reset  : high while no valid image is loaded
//   done       : image loaded, CPU released
//   error      : bad length header received
// -----------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  imem_boot_loader_if.master         bus,
  output logic                       cpu_reset,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  boot_state_t            state_q;
  logic [ADDR_W-1:0]      idx_q;
  logic [ADDR_W-1:0]      last_q;     // stored as N-1 so N = depth fits ADDR_W bits
  logic                   we_q;
  logic                   cpu_reset_q;
  logic                   done_q;
  logic                   error_q;

  logic                   byte_ready_s;
  logic                   clr_s;
  logic                   shift_en_s;
  logic                   word_full_s;
  logic [BOOT_WORD_W-1:0] word_s;

  // Ready is a pure function of state so a byte offered in WRITE, DONE or ERR
  // simply waits at the source.
  always_comb begin
    byte_ready_s = 1'b0;
    case (state_q)
      LEN, BYTES: byte_ready_s = 1'b1;
      default:    byte_ready_s = 1'b0;
    endcase
  end

  // Header acceptance restarts the assembler; bytes shift only in BYTES.
  always_comb begin
    clr_s      = 1'b0;
    shift_en_s = 1'b0;
    if (state_q == LEN) begin
      clr_s = bus.byte_valid;
    end else if (state_q == BYTES) begin
      shift_en_s = bus.byte_valid;
    end else begin
      clr_s      = 1'b0;
      shift_en_s = 1'b0;
    end
  end

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr_s),
    .shift_en  (shift_en_s),
    .byte_in   (bus.byte_data),
    .word_out  (word_s),
    .word_full (word_full_s)
  );

  // Loader FSM with index/length registers and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LEN;
      idx_q       <= '0;
      last_q      <= '0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        LEN: begin
          if (bus.byte_valid) begin
            if (hdr_valid(bus.byte_data, DEPTH)) begin
              // Truncation is intended: for N = depth the low bits are 0 and
              // subtracting one wraps to depth-1.
              last_q  <= ADDR_W'(bus.byte_data) - ADDR_W'(1'b1);
              idx_q   <= '0;
              state_q <= BYTES;
            end else begin
              error_q <= 1'b1;
              state_q <= ERR;
            end
          end
        end
        BYTES: begin
          if (word_full_s) begin
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (idx_q == last_q) begin
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
            state_q     <= DONE;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1'b1);
            state_q <= BYTES;
          end
        end
        DONE: begin
          if (load_start) begin
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
            state_q     <= LEN;
          end
        end
        ERR: begin
          if (load_start) begin
            error_q <= 1'b0;
            state_q <= LEN;
          end
        end
        default: begin
          done_q      <= 1'b0;
          error_q     <= 1'b0;
          cpu_reset_q <= 1'b1;
          state_q     <= LEN;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_s;
  assign bus.imem_we    = we_q;
  assign bus.imem_wa    = idx_q;   // stable through WRITE, advanced on leaving it
  assign bus.imem_wd    = word_s;  // assembler holds the word while in WRITE
  assign cpu_reset      = cpu_reset_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
  import imem_boot_pkg::*;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  logic load_start;
  logic cpu_reset;
  logic done;
  logic error;

  imem_boot_loader_if #(.ADDR_W(AW)) bus ();

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned       cyc;
  logic [31:0]       img_q[$];
  logic [31:0]       img5_q[$];
  logic [7:0]        stream_q[$];
  logic [AW+31:0]    got_q[$];
  logic [31:0]       mem_m [DEPTH];
  int                rdy_viol = 0;
  int                xfer_cnt = 0;

  // Edge counter since reset release
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  // Passive monitor: records memory writes and byte transfers
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.imem_we) begin
        got_q.push_back({bus.imem_wa, bus.imem_wd});
        mem_m[bus.imem_wa] <= bus.imem_wd;
        if (bus.byte_ready) rdy_viol <= rdy_viol + 1;
      end
      if (bus.byte_valid && bus.byte_ready) xfer_cnt <= xfer_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte (after an optional random idle gap) until it is taken.
  // Must be called at posedge+1.
  task automatic push_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    @(negedge clk);
    while (!bus.byte_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    check("hs_ready", 64'(bus.byte_ready), 64'd1);
    tick();
    bus.byte_valid = 1'b0;
  endtask

  // Stream = header byte, then each word MSB first
  task automatic build_stream(input int n_hdr);
    stream_q.delete();
    stream_q.push_back(8'(n_hdr));
    foreach (img_q[i])
      for (int k = 3; k >= 0; k--) stream_q.push_back(img_q[i][8*k +: 8]);
  endtask

  task automatic push_range(input int lo, input int hi, input int max_gap);
    for (int i = lo; i < hi; i++) push_byte(stream_q[i], max_gap);
  endtask

  task automatic make_image(input int n);
    img_q.delete();
    repeat (n) img_q.push_back($urandom);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int base);
    int n_got;
    n_got = got_q.size() - base;
    check({tag, "_nwrites"}, 64'(n_got), 64'(img_q.size()));
    for (int i = 0; i < img_q.size() && i < n_got; i++)
      check($sformatf("%s_w%0d", tag, i), 64'(got_q[base+i]), {26'd0, AW'(i), img_q[i]});
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    int base;
    int xbase;
    int mism;

    reset          = 1'b1;
    load_start     = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    64'(bus.imem_we),    64'd0);
    check("rst_wa",    64'(bus.imem_wa),    64'd0);
    check("rst_wd",    64'(bus.imem_wd),    64'd0);
    check("rst_ready", 64'(bus.byte_ready), 64'd1);
    check("rst_cpu",   64'(cpu_reset),      64'd1);
    check("rst_done",  64'(done),           64'd0);
    check("rst_err",   64'(error),          64'd0);
    reset = 1'b0;

    // T1: two-word directed image, valid held high
    img_q.delete();
    img_q.push_back(32'h2008_0005);
    img_q.push_back(32'h8C02_0000);
    build_stream(2);
    base = got_q.size();
    push_range(0, stream_q.size(), 0);
    @(negedge clk);
    check("t1_cyc10",      64'(cyc),          64'd10);
    check("t1_we_last",    64'(bus.imem_we),  64'd1);
    check("t1_done_early", 64'(done),         64'd0);
    @(negedge clk);
    check("t1_cyc11",  64'(cyc),         64'd11);
    check("t1_done",   64'(done),        64'd1);
    check("t1_cpu",    64'(cpu_reset),   64'd0);
    check("t1_we_off", 64'(bus.imem_we), 64'd0);
    check_writes("t1", base);

    // T2: bad headers 0x00 and 0x41
    for (int h = 0; h < 2; h++) begin
      tick();
      pulse_start();
      check("t2_cpu_up", 64'(cpu_reset),      64'd1);
      check("t2_ready",  64'(bus.byte_ready), 64'd1);
      base = got_q.size();
      push_byte((h == 0) ? 8'h00 : 8'h41, 0);
      @(negedge clk);
      check("t2_err",     64'(error),          64'd1);
      check("t2_err_cpu", 64'(cpu_reset),      64'd1);
      check("t2_err_rdy", 64'(bus.byte_ready), 64'd0);
      repeat (3) @(negedge clk);
      check("t2_nowrite", 64'(got_q.size() - base), 64'd0);
      tick();
      pulse_start();
      check("t2_err_clr", 64'(error),          64'd0);
      check("t2_len_rdy", 64'(bus.byte_ready), 64'd1);
      // back in LEN: first iteration needs ERR->LEN->(next header) path,
      // second iteration ends in LEN for T3
      if (h == 0) begin
        push_byte(8'h00, 0);
      end
    end

    // T3: 18-word random image with random valid gaps
    make_image(18);
    build_stream(18);
    base  = got_q.size();
    xbase = xfer_cnt;
    push_range(0, stream_q.size(), 3);
    wait_done("t3");
    check_writes("t3", base);
    check("t3_xfers",   64'(xfer_cnt - xbase), 64'(1 + 4 * 18));
    check("t3_rdy_we",  64'(rdy_viol),         64'd0);

    // T4: reset after 2 bytes of word 3, then a fresh 1-word load
    tick();
    pulse_start();
    make_image(5);
    build_stream(5);
    push_range(0, 1 + 4 * 3 + 2, 0);
    #2;
    reset = 1'b1;
    #1;
    check("t4_we",    64'(bus.imem_we),    64'd0);
    check("t4_wd",    64'(bus.imem_wd),    64'd0);
    check("t4_ready", 64'(bus.byte_ready), 64'd1);
    check("t4_cpu",   64'(cpu_reset),      64'd1);
    tick();
    reset = 1'b0;
    img_q.delete();
    img_q.push_back(32'hDEAD_BEEF);
    build_stream(1);
    base = got_q.size();
    push_range(0, stream_q.size(), 0);
    wait_done("t4");
    repeat (2) @(negedge clk);
    check_writes("t4", base);

    // T5: reload from DONE with a full-depth image
    tick();
    check("t5_cpu_low", 64'(cpu_reset), 64'd0);
    pulse_start();
    check("t5_cpu_up",  64'(cpu_reset), 64'd1);
    check("t5_done_lo", 64'(done),      64'd0);
    make_image(DEPTH);
    img5_q = img_q;
    build_stream(DEPTH);
    base = got_q.size();
    push_range(0, stream_q.size(), 0);
    wait_done("t5");
    check_writes("t5", base);

    // T6: load_start mid-BYTES is ignored; words above N stay intact
    tick();
    pulse_start();
    make_image(3);
    build_stream(3);
    base = got_q.size();
    push_range(0, 6, 0);
    pulse_start();
    check("t6_ready", 64'(bus.byte_ready), 64'd1);
    check("t6_cpu",   64'(cpu_reset),      64'd1);
    push_range(6, stream_q.size(), 0);
    wait_done("t6");
    check_writes("t6", base);
    mism = 0;
    for (int a = 0; a < DEPTH; a++)
      if (mem_m[a] !== ((a < 3) ? img_q[a] : img5_q[a])) mism++;
    check("t6_mem_untouched", 64'(mism), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
